// File: rtl/wb_cmd_master_pkg.sv
// Shared definitions for the Wishbone command initiator.
// Holds the FSM encoding, the default widths, the timeout default and the
// response data pattern returned on a timeout abort.
package wb_cmd_master_pkg;

    localparam int unsigned DEFAULT_ADR_W   = 32;
    localparam int unsigned DEFAULT_DAT_W   = 32;
    localparam int unsigned DEFAULT_TIMEOUT = 255;

    localparam logic [DEFAULT_DAT_W-1:0] RSP_ERR_DATA = '1;

    // Legacy encodings kept as named constants; the enum is built on them.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUS  = ST_BUS,
        RESP = ST_RESP
    } state_t;

endpackage

// File: rtl/wb_cmd_timeout.sv
// Bus-cycle watchdog for wb_cmd_master.
// Counts enabled cycles since the last clear; expired is raised during the
// cycle that would be the TIMEOUT_CYCLES-th enabled cycle, so the owner can
// abort on that same edge.
module wb_cmd_timeout
    import wb_cmd_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

    // Count ack-less bus cycles; saturates once the limit is hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one command in, one bus cycle, one response out.
// Optional bus watchdog enabled by defining WB_CMD_MASTER_TIMEOUT_EN; without
// it the bus phase waits for ack indefinitely and rsp_err stays 0.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int unsigned ADR_W          = DEFAULT_ADR_W,
    parameter int unsigned DAT_W          = DEFAULT_DAT_W,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_we,
    input  logic [ADR_W-1:0]   cmd_adr,
    input  logic [DAT_W-1:0]   cmd_dat,
    input  logic [DAT_W/8-1:0] cmd_sel,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DAT_W-1:0]   rsp_dat,
    output logic               rsp_err,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [ADR_W-1:0]   wbm_adr_o,
    output logic [DAT_W-1:0]   wbm_dat_o,
    output logic [DAT_W/8-1:0] wbm_sel_o,
    input  logic [DAT_W-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i,
    output logic               busy
);

    state_t state;
    logic   accept;
    logic   timed_out;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    wb_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clear   (accept),
        .enable  ((state == BUS) && !wbm_ack_i),
        .expired (timed_out)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timed_out          = 1'b0;
`endif

    // Command/bus/response sequencing; ack wins over a same-edge timeout.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                        wbm_sel_o <= cmd_sel;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        state     <= BUS;
                    end
                end
                BUS: begin
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (timed_out) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= '1;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
